// File: rtl/game_timer_pkg.sv
// game_timer_pkg: seven-segment patterns and default divider constants for game_timer
package game_timer_pkg;
  localparam int CLK_HZ  = 50_000_000;
  localparam int MOVE_HZ = 20;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [15:0][6:0] SEG_LUT = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                          SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
endpackage

// File: rtl/game_timer_seg7_decoder.sv
// seg7_decoder: 4-bit hex value to active-low segments (bit0=a .. bit6=g)
module seg7_decoder
  import game_timer_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[val];
endmodule

// File: rtl/game_timer.sv
// game_timer: move/second tick prescalers and an MM:SS BCD elapsed-time display
module game_timer
  import game_timer_pkg::*;
#(
  parameter int SEC_DIV  = CLK_HZ,
  parameter int MOVE_DIV = CLK_HZ / MOVE_HZ
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       run,
  output logic       move_tick,
  output logic       sec_tick,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);
  localparam int SW = $clog2(SEC_DIV);
  localparam int MW = $clog2(MOVE_DIV);
  logic [SW-1:0] scnt_q, scnt_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic          move_tick_q, move_tick_d, sec_tick_q, sec_tick_d;
  logic [3:0]    s0_q, s0_d, s1_q, s1_d, m0_q, m0_d, m1_q, m1_d;
  logic          mwrap, swrap, c0, c1, c2;
  always_comb begin
    mwrap       = mcnt_q == MW'(MOVE_DIV - 1);
    swrap       = scnt_q == SW'(SEC_DIV - 1);
    mcnt_d      = !run ? '0 : mwrap ? '0 : mcnt_q + 1'b1;
    scnt_d      = !run ? '0 : swrap ? '0 : scnt_q + 1'b1;
    move_tick_d = run && mwrap;
    sec_tick_d  = run && swrap;
    // each carry only fires when every lower digit is rolling over on the same second
    c0          = sec_tick_q && s0_q == 4'd9;
    c1          = c0 && s1_q == 4'd5;
    c2          = c1 && m0_q == 4'd9;
    s0_d        = !run ? '0 : sec_tick_q ? (s0_q == 4'd9 ? '0 : s0_q + 4'd1) : s0_q;
    s1_d        = !run ? '0 : c0 ? (s1_q == 4'd5 ? '0 : s1_q + 4'd1) : s1_q;
    m0_d        = !run ? '0 : c1 ? (m0_q == 4'd9 ? '0 : m0_q + 4'd1) : m0_q;
    m1_d        = !run ? '0 : c2 ? (m1_q == 4'd9 ? '0 : m1_q + 4'd1) : m1_q;
  end
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      scnt_q      <= '0;
      mcnt_q      <= '0;
      move_tick_q <= 1'b0;
      sec_tick_q  <= 1'b0;
      s0_q        <= '0;
      s1_q        <= '0;
      m0_q        <= '0;
      m1_q        <= '0;
    end else begin
      scnt_q      <= scnt_d;
      mcnt_q      <= mcnt_d;
      move_tick_q <= move_tick_d;
      sec_tick_q  <= sec_tick_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      m0_q        <= m0_d;
      m1_q        <= m1_d;
    end
  end
  assign move_tick = move_tick_q;
  assign sec_tick  = sec_tick_q;
  seg7_decoder u_hex0 (.val(s0_q), .seg(HEX0));
  seg7_decoder u_hex1 (.val(s1_q), .seg(HEX1));
  seg7_decoder u_hex2 (.val(m0_q), .seg(HEX2));
  seg7_decoder u_hex3 (.val(m1_q), .seg(HEX3));
endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: scoreboard bench; expected outputs derived from cycles elapsed since the last clear
module tb_game_timer;
  localparam int SEC_DIV  = 10;
  localparam int MOVE_DIV = 4;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       run = 1'b0;
  logic       move_tick, sec_tick;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic [3:0] dec_val = '0;
  logic [6:0] dec_seg;
  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [29:0] sb_q [$];
  int vectors = 0;
  int miscompares = 0;
  int n = 0;
  always #5 clk = ~clk;
  game_timer #(.SEC_DIV(SEC_DIV), .MOVE_DIV(MOVE_DIV)) dut (
    .CLOCK_50(clk), .resetn(resetn), .run(run), .move_tick(move_tick), .sec_tick(sec_tick),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3)
  );
  seg7_decoder u_dec (.val(dec_val), .seg(dec_seg));
  task automatic check(input string tag, input logic [29:0] got, input logic [29:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [29:0] model(input int c);
    int secs, ss, mm;
    secs = c == 0 ? 0 : (c - 1) / SEC_DIV;
    ss   = secs % 60;
    mm   = (secs / 60) % 100;
    return {c > 0 && c % MOVE_DIV == 0, c > 0 && c % SEC_DIV == 0,
            seg_tab[mm / 10], seg_tab[mm % 10], seg_tab[ss / 10], seg_tab[ss % 10]};
  endfunction
  task automatic step(input logic rn, input logic r);
    resetn = rn;
    run    = r;
    n      = (!rn || !r) ? 0 : n + 1;
    sb_q.push_back(model(n));
    @(posedge clk);
    #1;
    check($sformatf("cyc%0d", n), {move_tick, sec_tick, hex3, hex2, hex1, hex0}, sb_q.pop_front());
  endtask
  initial begin
    repeat (2) step(1'b0, 1'b1);
    check("reset_clear", {move_tick, sec_tick, hex3, hex2, hex1, hex0}, {2'b00, {4{7'b1000000}}});
    repeat (3) step(1'b1, 1'b1);
    check("no_move_c3", {29'd0, move_tick}, 30'd0);
    step(1'b1, 1'b1);
    check("first_move_c4", {29'd0, move_tick}, 30'd1);
    repeat (5) step(1'b1, 1'b1);
    check("no_sec_c9", {29'd0, sec_tick}, 30'd0);
    step(1'b1, 1'b1);
    check("first_sec_c10", {29'd0, sec_tick}, 30'd1);
    repeat (85) step(1'b1, 1'b1);
    check("nine_secs", {16'd0, hex1, hex0}, {16'd0, 7'b1000000, 7'b0010000});
    repeat (10) step(1'b1, 1'b1);
    check("ten_secs", {23'd0, hex1}, {23'd0, 7'b1111001});
    repeat (500) step(1'b1, 1'b1);
    check("one_minute", {2'b00, hex3, hex2, hex1, hex0},
          {2'b00, 7'b1000000, 7'b1111001, 7'b1000000, 7'b1000000});
    step(1'b1, 1'b0);
    repeat (75) step(1'b1, 1'b1);
    check("at_0007", {23'd0, hex0}, {23'd0, 7'b1111000});
    step(1'b1, 1'b0);
    check("pause_clear", {move_tick, sec_tick, hex3, hex2, hex1, hex0}, {2'b00, {4{7'b1000000}}});
    repeat (9) step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("restart_sec_c10", {29'd0, sec_tick}, 30'd1);
    repeat (5) step(1'b1, 1'b0);
    repeat (60000) step(1'b1, 1'b1);
    check("at_9959", {2'b00, hex3, hex2, hex1, hex0},
          {2'b00, 7'b0010000, 7'b0010000, 7'b0010010, 7'b0010000});
    repeat (2) step(1'b1, 1'b1);
    check("wrap_0000", {2'b00, hex3, hex2, hex1, hex0}, {2'b00, {4{7'b1000000}}});
    repeat (2) step(1'b0, 1'b1);
    for (int v = 0; v < 16; v++) begin
      dec_val = 4'(v);
      sb_q.push_back({23'd0, seg_tab[v]});
      #1;
      check($sformatf("dec%0d", v), {23'd0, dec_seg}, sb_q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
- Elapsed-time and tick-generation block for the two-player tron game.
- Derives a periodic movement tick and a 1 Hz tick from CLOCK_50.
- Counts elapsed game time as MM:SS in BCD and drives four 7-segment displays, HEX3..HEX0.
- Sits beside the game datapath: move_tick steps the snakes; the HEX outputs go straight to board pins.

Parameters:
- SEC_DIV, 50_000_000: CLOCK_50 cycles per second tick; minimum 2.
- MOVE_DIV, 2_500_000: CLOCK_50 cycles per movement tick (20 Hz); minimum 2.

Ports:
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- resetn  in  1  synchronous, active-low reset.
- run  in  1  game-running level (board switch SW[17]); 0 = game held in reset.
- move_tick  out  1  one-cycle pulse every MOVE_DIV cycles while running.
- sec_tick  out  1  one-cycle pulse every SEC_DIV cycles while running.
- HEX0  out  7  seconds ones digit, active-low segments.
- HEX1  out  7  seconds tens digit.
- HEX2  out  7  minutes ones digit.
- HEX3  out  7  minutes tens digit.

Behaviour:
- One clock, CLOCK_50. Reset is synchronous and active-low. No other clocks; ticks are enables, not derived clocks.
- Clear condition = (resetn==0) OR (run==0). resetn has priority, but both have the same effect. On clear:
  - both prescalers go to 0;
  - all four BCD digits go to 0;
  - move_tick = 0 and sec_tick = 0;
  - every HEX shows "0" (7'b1000000).
- Movement prescaler:
  - counts 0..MOVE_DIV-1 while run=1, then wraps to 0;
  - move_tick is registered: it is high for exactly the one cycle after the prescaler holds MOVE_DIV-1.
  - Result: first pulse MOVE_DIV cycles after run rises; period is MOVE_DIV thereafter.
- Second prescaler:
  - same structure with SEC_DIV; drives sec_tick.
- Time counter: advances on the edge where sec_tick=1. BCD digits:
  - s0 0..9; s1 0..5; m0 0..9; m1 0..9.
  - Carry rules: s0 9→0 increments s1; s1 5→0 (with s0 carry) increments m0; m0 9→0 increments m1.
  - 99:59 wraps to 00:00; no saturation and no overflow flag.
  - The display changes one cycle after the sec_tick pulse.
- Digit values never exceed their ranges above; values 10..15 are unreachable.
- Segment decode:
  - combinational from the digit registers; bit0=a .. bit6=g; 0 = lit.
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000.
  - A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110 (full hex decoder, reusable elsewhere).
- Pause/restart: run falling mid-second clears everything, so timing on restart is exact from zero. run held low keeps all outputs at their clear values.
- Two prescalers hitting terminal on the same cycle: both ticks pulse together; they are independent.

Decomposition:
- Package game_timer_pkg:
  - seven-segment constants SEG_0..SEG_F;
  - default divider constants CLK_HZ=50_000_000 and MOVE_HZ=20.
- Sub-module seg7_decoder: 4-bit value in, 7-bit active-low segments out, purely combinational. Instantiated four times.
- Prescalers and the BCD chain stay in game_timer; the prescaler may be a generate-style local block but is not a separate module.

Test Plan (SEC_DIV=10, MOVE_DIV=4):
- Reset: resetn=0 for 2 cycles with run=1 -> HEX0..HEX3 = 7'b1000000, both ticks 0; release -> move_tick first high on cycle 4, then every 4 cycles; sec_tick first high on cycle 10.
- Seconds count: run=1 for 95 cycles after reset -> 9 sec_ticks; HEX0 = 7'b0010000 ("9"), HEX1 = "0".
- Carries: run through 60 sec_ticks -> display 01:00 (HEX2 = 7'b1111001, HEX1 = HEX0 = "0"); at 10 ticks HEX1 = "1".
- Wrap: run through 6000 sec_ticks -> 99:59 → 00:00; all HEX = "0".
- Pause clear: drop run mid-count at 00:07 for 1 cycle, then raise -> display 00:00 immediately; next sec_tick exactly 10 cycles after run returns.
- Decoder: drive seg7_decoder exhaustively 0..15 -> matches the 16 patterns above.
